// File: rtl/e15_prog_loader_pkg.sv
// Shared constants, instruction field layout and loader FSM encoding.
package e15_prog_loader_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 12;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;

  localparam int unsigned OP_MSB  = 11;
  localparam int unsigned OP_LSB  = 8;
  localparam int unsigned SRC_MSB = 7;
  localparam int unsigned SRC_LSB = 6;
  localparam int unsigned DST_MSB = 5;
  localparam int unsigned DST_LSB = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]   opcode;
    logic [SRC_MSB-SRC_LSB:0] src;
    logic [DST_MSB-DST_LSB:0] dst;
    logic [IMM_MSB-IMM_LSB:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

endpackage

// File: rtl/e15_prog_loader_if.sv
// Host load channel and processor fetch port of the program loader.
interface e15_prog_loader_if;
  import e15_prog_loader_pkg::*;

  logic          load_start;
  logic [AW-1:0] load_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_data;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          cpu_run;
  logic          load_done;
  logic [CW-1:0] words_loaded;

  modport master (
    output load_start, load_len, wr_valid, wr_data, pc,
    input  wr_ready, instr, cpu_run, load_done, words_loaded
  );

  modport slave (
    input  load_start, load_len, wr_valid, wr_data, pc,
    output wr_ready, instr, cpu_run, load_done, words_loaded
  );

endinterface

// File: rtl/e15_imem.sv
// Instruction store: register array, one synchronous write port, one combinational read port.
module e15_imem
  import e15_prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);

  instr_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= instr_t'(i_wdata);
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/e15_prog_loader.sv
// Program loader: accepts a counted burst of instruction words, then runs the processor from them.
module e15_prog_loader
  import e15_prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  e15_prog_loader_if.slave   bus
);

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_target;
  logic [CW-1:0] r_words;
  logic          r_done;
  logic          w_wr_ready;
  logic          w_we;
  logic          w_last;
  logic          w_start;
  logic [CW-1:0] w_words_inc;
  logic [IW-1:0] w_rdata;

  assign w_words_inc = r_words + CW'(1);
  assign w_last      = (w_words_inc == r_target);

  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_we         = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.load_start) begin
          w_state_next = StLoad;
          w_start      = 1'b1;
        end
      end
      StLoad: begin
        w_wr_ready = 1'b1;
        if (bus.wr_valid) begin
          w_we = 1'b1;
          if (w_last) w_state_next = StRun;
        end
      end
      StRun: begin
        if (bus.load_start) begin
          w_state_next = StLoad;
          w_start      = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_target <= '0;
      r_words  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_we && w_last;
      if (w_start) begin
        r_target <= {1'b0, bus.load_len} + CW'(1);
        r_words  <= '0;
      end else if (w_we) begin
        r_words <= w_words_inc;
      end
    end
  end

  // Write index never exceeds 15: the final transfer of a 16-word load leaves LOAD.
  e15_imem u_imem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_words[AW-1:0]),
    .i_wdata (bus.wr_data),
    .i_raddr (bus.pc),
    .o_rdata (w_rdata)
  );

  assign bus.wr_ready     = w_wr_ready;
  assign bus.cpu_run      = (r_state == StRun);
  assign bus.instr        = (r_state == StRun) ? w_rdata : '0;
  assign bus.load_done    = r_done;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_e15_prog_loader.sv
// Self-checking bench for e15_prog_loader: directed table, corner sequences, random vs model.
module tb_e15_prog_loader;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  e15_prog_loader_if bus ();

  e15_prog_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program image plus load bookkeeping.
  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MRun  = 2;
  logic [11:0] m_mem [16];
  int          m_mode;
  int          m_target;
  int          m_count;
  bit          m_done;

  typedef struct {
    bit          ls;
    logic [3:0]  len;
    bit          v;
    logic [11:0] d;
    logic [3:0]  pc;
    bit          e_ready;
    bit          e_run;
    bit          e_done;
    int          e_words;
    logic [11:0] e_instr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 12'h000;
    m_mode   = MIdle;
    m_target = 0;
    m_count  = 0;
    m_done   = 1'b0;
  endtask

  task automatic apply(input bit ls, input logic [3:0] len, input bit v, input logic [11:0] d,
                       input logic [3:0] p);
    @(negedge clk);
    bus.load_start = ls;
    bus.load_len   = len;
    bus.wr_valid   = v;
    bus.wr_data    = d;
    bus.pc         = p;
    #1;
  endtask

  task automatic check_model();
    check("wr_ready", 32'(bus.wr_ready), 32'(m_mode == MLoad));
    check("cpu_run", 32'(bus.cpu_run), 32'(m_mode == MRun));
    check("load_done", 32'(bus.load_done), 32'(m_done));
    check("words_loaded", 32'(bus.words_loaded), 32'(m_count));
    check("instr", 32'(bus.instr), 32'((m_mode == MRun) ? m_mem[bus.pc] : 12'h000));
  endtask

  // Advance one clock and apply the load rules to the model with the inputs just seen.
  task automatic advance();
    @(posedge clk);
    m_done = 1'b0;
    if (m_mode == MLoad) begin
      if (bus.wr_valid) begin
        m_mem[m_count] = bus.wr_data;
        m_count++;
        if (m_count == m_target) begin
          m_mode = MRun;
          m_done = 1'b1;
        end
      end
    end else if (bus.load_start) begin
      m_mode   = MLoad;
      m_target = int'(bus.load_len) + 1;
      m_count  = 0;
    end
  endtask

  task automatic step(input bit ls, input logic [3:0] len, input bit v, input logic [11:0] d,
                      input logic [3:0] p);
    apply(ls, len, v, d, p);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst cpu_run", 32'(bus.cpu_run), 32'd0);
    check("rst wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst load_done", 32'(bus.load_done), 32'd0);
    check("rst words", 32'(bus.words_loaded), 32'd0);
    for (int p = 0; p < 16; p += 5) begin
      bus.pc = 4'(p);
      #1;
      check("rst instr", 32'(bus.instr), 32'd0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [9];

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.pc         = '0;
    model_reset();

    // Basic 4-word load, back-to-back, then fetches and a dropped write in RUN.
    tbl[0] = '{1, 4'd3, 0, 12'h000, 4'd0, 0, 0, 0, 0, 12'h000};
    tbl[1] = '{0, 4'd0, 1, 12'h105, 4'd0, 1, 0, 0, 0, 12'h000};
    tbl[2] = '{0, 4'd0, 1, 12'h210, 4'd0, 1, 0, 0, 1, 12'h000};
    tbl[3] = '{0, 4'd0, 1, 12'h3C1, 4'd0, 1, 0, 0, 2, 12'h000};
    tbl[4] = '{0, 4'd0, 1, 12'hF00, 4'd0, 1, 0, 0, 3, 12'h000};
    tbl[5] = '{0, 4'd0, 0, 12'h000, 4'd2, 0, 1, 1, 4, 12'h3C1};
    tbl[6] = '{0, 4'd0, 0, 12'h000, 4'd0, 0, 1, 0, 4, 12'h105};
    tbl[7] = '{0, 4'd0, 1, 12'hABC, 4'd3, 0, 1, 0, 4, 12'hF00};
    tbl[8] = '{0, 4'd0, 0, 12'h000, 4'd3, 0, 1, 0, 4, 12'hF00};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].ls, tbl[i].len, tbl[i].v, tbl[i].d, tbl[i].pc);
      check($sformatf("t%0d wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].e_ready));
      check($sformatf("t%0d cpu_run", i), 32'(bus.cpu_run), 32'(tbl[i].e_run));
      check($sformatf("t%0d load_done", i), 32'(bus.load_done), 32'(tbl[i].e_done));
      check($sformatf("t%0d words", i), 32'(bus.words_loaded), 32'(tbl[i].e_words));
      check($sformatf("t%0d instr", i), 32'(bus.instr), 32'(tbl[i].e_instr));
      advance();
    end
    for (int p = 0; p < 4; p++) step(0, 4'd0, 0, 12'h000, 4'(p));

    // Gapped load: valid one cycle in three; load_start with len 15 mid-load is ignored.
    step(1, 4'd3, 0, 12'h000, 4'd0);
    for (int w = 0; w < 4; w++) begin
      step(0, 4'd0, 0, 12'h000, 4'd0);
      step(w == 1, 4'd15, 0, 12'h000, 4'd0);
      step(0, 4'd0, 1, 12'h400 + 12'(w), 4'd0);
    end
    for (int p = 0; p < 5; p++) step(0, 4'd0, 0, 12'h000, 4'(p));

    // Full 16-word load: no wrap, count reaches 16.
    step(1, 4'd15, 0, 12'h000, 4'd0);
    for (int w = 0; w < 16; w++) step(0, 4'd0, 1, 12'(w), 4'd0);
    apply(0, 4'd0, 0, 12'h000, 4'd15);
    check("full words", 32'(bus.words_loaded), 32'd16);
    check("full pc15", 32'(bus.instr), 32'h00F);
    advance();
    for (int p = 0; p < 16; p++) step(0, 4'd0, 0, 12'h000, 4'(p));

    // Reset in the middle of a load, then a fresh one-word load over a cleared memory.
    step(1, 4'd3, 0, 12'h000, 4'd0);
    step(0, 4'd0, 1, 12'h111, 4'd0);
    step(0, 4'd0, 1, 12'h222, 4'd0);
    do_reset();
    step(0, 4'd0, 1, 12'hABC, 4'd0);
    check("idle drop words", 32'(bus.words_loaded), 32'd0);
    step(1, 4'd0, 0, 12'h000, 4'd0);
    step(0, 4'd0, 1, 12'h123, 4'd0);
    for (int p = 0; p < 16; p++) step(0, 4'd0, 0, 12'h000, 4'(p));

    // Reload from RUN: 4 words, then a 1-word reload keeps entries 1..3.
    step(1, 4'd3, 0, 12'h000, 4'd0);
    step(0, 4'd0, 1, 12'h111, 4'd0);
    step(0, 4'd0, 1, 12'h222, 4'd0);
    step(0, 4'd0, 1, 12'h333, 4'd0);
    step(0, 4'd0, 1, 12'h444, 4'd0);
    step(1, 4'd0, 0, 12'h000, 4'd1);
    step(0, 4'd0, 0, 12'h000, 4'd1);
    step(0, 4'd0, 1, 12'h777, 4'd1);
    apply(0, 4'd0, 0, 12'h000, 4'd0);
    check("reload pc0", 32'(bus.instr), 32'h777);
    advance();
    apply(0, 4'd0, 0, 12'h000, 4'd1);
    check("reload pc1", 32'(bus.instr), 32'h222);
    advance();
    for (int p = 0; p < 4; p++) step(0, 4'd0, 0, 12'h000, 4'(p));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 2) != 0,
           12'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
